// File: rtl/neuraedge_pe_requant.sv
// Requantizer behind a PE accumulator: bias, scale, round-shift and clamp
// in a 3-stage pipeline feeding an output FIFO with a saturation counter.
module neuraedge_pe_requant #(
   parameter int unsigned ACCUM_WIDTH = 32,
   parameter int unsigned OUT_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [ACCUM_WIDTH-1:0] in_accum,
   input  logic                   cfg_load,
   input  logic [15:0]            cfg_mult,
   input  logic [4:0]             cfg_shift,
   input  logic [ACCUM_WIDTH-1:0] cfg_bias,
   input  logic                   cfg_relu,
   input  logic [1:0]             cfg_precision,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [OUT_WIDTH-1:0]   out_data,
   output logic                   out_sat,
   input  logic                   stat_clear,
   output logic [15:0]            sat_count,
   output logic                   busy
);

   localparam int unsigned SW   = ACCUM_WIDTH + 1;
   localparam int unsigned PW   = SW + 17;
   localparam int unsigned RW   = (PW + 1 > 34) ? PW + 1 : 34;
   localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic [1:0] {
      PREC_INT8 = 2'd0,
      PREC_INT4 = 2'd1,
      PREC_INT2 = 2'd2,
      PREC_INT1 = 2'd3
   } prec_e;

   logic [15:0]            cfg_mult_q;
   logic [4:0]             cfg_shift_q;
   logic [ACCUM_WIDTH-1:0] cfg_bias_q;
   logic                   cfg_relu_q;
   prec_e                  cfg_prec_q;

   logic                   s1_vld_q, s2_vld_q, s3_vld_q;
   logic signed [SW-1:0]   s1_sum_q, s1_sum_d;
   logic signed [PW-1:0]   s2_prod_q, s2_prod_d;
   logic [OUT_WIDTH-1:0]   s3_data_q, s3_data_d;
   logic                   s3_sat_q, s3_sat_d;

   logic [CW-1:0]          occ_q, occ_d, fcnt_q, fcnt_d;
   logic [PTRW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [OUT_WIDTH:0]     mem_q [FIFO_DEPTH];
   logic [15:0]            sat_cnt_q, sat_cnt_d;

   logic                   accept, pop;
   logic signed [RW-1:0]   rnd_ext, rnd_half, rnd_sum, rnd, lo_w, hi_w, clamped;
   logic signed [8:0]      lo, hi;

   // Occupancy covers pipeline and FIFO, so in_ready never depends on out_ready.
   assign in_ready  = (occ_q < CW'(FIFO_DEPTH));
   assign busy      = (occ_q != '0);
   assign out_valid = (fcnt_q != '0);
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem_q[rd_ptr_q][OUT_WIDTH-1:0] : '0;
   assign out_sat   = out_valid && mem_q[rd_ptr_q][OUT_WIDTH];
   assign sat_count = sat_cnt_q;

   always_comb begin
      s1_sum_d  = $signed({in_accum[ACCUM_WIDTH-1], in_accum})
                + $signed({cfg_bias_q[ACCUM_WIDTH-1], cfg_bias_q});
      s2_prod_d = PW'(s1_sum_q) * PW'($signed({1'b0, cfg_mult_q}));

      rnd_ext  = RW'(s2_prod_q);
      rnd_half = RW'(1) << (cfg_shift_q - 5'd1);
      rnd_sum  = rnd_ext + rnd_half;
      rnd      = (cfg_shift_q == 5'd0) ? rnd_ext : (rnd_sum >>> cfg_shift_q);

      lo = -9'sd128;
      hi = 9'sd127;
      case (cfg_prec_q)
         PREC_INT8: begin lo = -9'sd128; hi = 9'sd127; end
         PREC_INT4: begin lo = -9'sd8;   hi = 9'sd7;   end
         PREC_INT2: begin lo = -9'sd2;   hi = 9'sd1;   end
         PREC_INT1: begin lo = 9'sd0;    hi = 9'sd1;   end
         default:   begin lo = -9'sd128; hi = 9'sd127; end
      endcase
      if (cfg_relu_q) lo = '0;
      lo_w = RW'(lo);
      hi_w = RW'(hi);

      clamped  = rnd;
      s3_sat_d = 1'b0;
      if (rnd > hi_w) begin
         clamped  = hi_w;
         s3_sat_d = 1'b1;
      end else if (rnd < lo_w) begin
         clamped  = lo_w;
         s3_sat_d = 1'b1;
      end
      s3_data_d = clamped[OUT_WIDTH-1:0];
   end

   always_comb begin
      occ_d    = occ_q + CW'(accept) - CW'(pop);
      fcnt_d   = fcnt_q + CW'(s3_vld_q) - CW'(pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (s3_vld_q)
         wr_ptr_d = (wr_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTRW'(1);
      if (pop)
         rd_ptr_d = (rd_ptr_q == PTRW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTRW'(1);
      sat_cnt_d = sat_cnt_q;
      if (stat_clear)
         sat_cnt_d = '0;
      else if (s3_vld_q && s3_sat_q && sat_cnt_q != '1)
         sat_cnt_d = sat_cnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_mult_q  <= 16'd1;
         cfg_shift_q <= '0;
         cfg_bias_q  <= '0;
         cfg_relu_q  <= 1'b0;
         cfg_prec_q  <= PREC_INT8;
         s1_vld_q    <= 1'b0;
         s2_vld_q    <= 1'b0;
         s3_vld_q    <= 1'b0;
         occ_q       <= '0;
         fcnt_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         sat_cnt_q   <= '0;
      end else begin
         if (cfg_load && !busy) begin
            cfg_mult_q  <= cfg_mult;
            cfg_shift_q <= cfg_shift;
            cfg_bias_q  <= cfg_bias;
            cfg_relu_q  <= cfg_relu;
            cfg_prec_q  <= prec_e'(cfg_precision);
         end
         s1_vld_q  <= accept;
         s2_vld_q  <= s1_vld_q;
         s3_vld_q  <= s2_vld_q;
         occ_q     <= occ_d;
         fcnt_q    <= fcnt_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         sat_cnt_q <= sat_cnt_d;
      end
   end

   // Datapath and storage are qualified by the valids, so they need no reset.
   always_ff @(posedge clk) begin
      if (accept)   s1_sum_q  <= s1_sum_d;
      if (s1_vld_q) s2_prod_q <= s2_prod_d;
      if (s2_vld_q) begin
         s3_data_q <= s3_data_d;
         s3_sat_q  <= s3_sat_d;
      end
      if (s3_vld_q) mem_q[wr_ptr_q] <= {s3_sat_q, s3_data_q};
   end

endmodule

// File: tb/tb_neuraedge_pe_requant.sv
// Directed self-checking bench for neuraedge_pe_requant with hand-computed
// expectations for latency, arithmetic, clamping, back-pressure and reset.
module tb_neuraedge_pe_requant;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_ready, cfg_load, cfg_relu;
   logic [31:0] in_accum, cfg_bias;
   logic [15:0] cfg_mult, sat_count;
   logic [4:0]  cfg_shift;
   logic [1:0]  cfg_precision;
   logic        out_valid, out_ready, out_sat, stat_clear, busy;
   logic [7:0]  out_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   neuraedge_pe_requant #(.ACCUM_WIDTH(32), .OUT_WIDTH(8), .FIFO_DEPTH(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_accum(in_accum), .cfg_load(cfg_load), .cfg_mult(cfg_mult),
      .cfg_shift(cfg_shift), .cfg_bias(cfg_bias), .cfg_relu(cfg_relu),
      .cfg_precision(cfg_precision), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_sat(out_sat), .stat_clear(stat_clear),
      .sat_count(sat_count), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] v);
      in_valid = 1'b1;
      in_accum = v;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic load_cfg(input logic [15:0] m, input logic [4:0] s, input logic [31:0] b,
                           input logic r, input logic [1:0] p);
      cfg_mult = m; cfg_shift = s; cfg_bias = b; cfg_relu = r; cfg_precision = p;
      cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && busy; i++) tick();
      check("drain_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int idx, got, first_c, last_c;
      logic acc;

      reset = 1'b1; in_valid = 1'b0; in_accum = '0; cfg_load = 1'b0;
      cfg_mult = 16'd1; cfg_shift = '0; cfg_bias = '0; cfg_relu = 1'b0;
      cfg_precision = '0; out_ready = 1'b1; stat_clear = 1'b0;
      tick(); tick();
      reset = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_sat", out_sat, 0);
      check("rst_sat_count", sat_count, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);

      // Latency: accept at edge N, visible after N+3
      send(100);
      check("lat_n_valid", out_valid, 0);
      check("lat_n_busy", busy, 1);
      tick(); check("lat_n1_valid", out_valid, 0);
      tick(); check("lat_n2_valid", out_valid, 0);
      tick(); check("lat_n3_valid", out_valid, 1);
      check("lat_data", out_data, 32'h64);
      check("lat_sat", out_sat, 0);
      tick(); check("lat_popped", out_valid, 0);
      check("lat_idle", busy, 0);

      // Scale/shift/bias with round-half-up
      load_cfg(16'd3, 5'd2, -32'sd1, 1'b0, 2'd0);
      send(10); send(-10);
      tick(); tick();
      check("rnd_pos_valid", out_valid, 1);
      check("rnd_pos", out_data, 32'h07);
      tick(); check("rnd_neg", out_data, 32'hF8);
      check("rnd_neg_sat", out_sat, 0);
      tick(); check("rnd_empty", out_valid, 0);

      // INT8 saturation and counter clear priority
      drain();
      load_cfg(16'd1, 5'd0, 32'd0, 1'b0, 2'd0);
      send(1000); send(-1000);
      tick(); tick();
      check("sat_hi", out_data, 32'h7F);
      check("sat_hi_flag", out_sat, 1);
      check("sat_cnt1", sat_count, 1);
      tick();
      check("sat_lo", out_data, 32'h80);
      check("sat_lo_flag", out_sat, 1);
      check("sat_cnt2", sat_count, 2);
      drain();
      check("sat_cnt_hold", sat_count, 2);
      send(1000); tick(); tick();
      stat_clear = 1'b1;
      tick();
      stat_clear = 1'b0;
      check("clr_valid", out_valid, 1);
      check("clr_sat_flag", out_sat, 1);
      check("clr_wins", sat_count, 0);
      tick(); check("clr_after", sat_count, 0);

      // INT4 with relu
      drain();
      load_cfg(16'd1, 5'd0, 32'd0, 1'b1, 2'd1);
      send(-5); send(20); send(3);
      tick(); check("i4_neg", out_data, 32'h00); check("i4_neg_sat", out_sat, 1);
      tick(); check("i4_big", out_data, 32'h07); check("i4_big_sat", out_sat, 1);
      tick(); check("i4_mid", out_data, 32'h03); check("i4_mid_sat", out_sat, 0);
      check("i4_cnt", sat_count, 2);

      // Back-pressure: only FIFO_DEPTH accepted, then in-order 1/cycle drain
      drain();
      load_cfg(16'd1, 5'd0, 32'd0, 1'b0, 2'd0);
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 1'b1;
         in_accum = idx + 1;
         acc = in_ready;
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check("bp_accepted", idx, 8);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_head", out_data, 32'd1);
      out_ready = 1'b1;
      got = 0; first_c = -1; last_c = -1;
      for (int c = 0; c < 40 && got < 12; c++) begin
         in_valid = (idx < 12);
         in_accum = idx + 1;
         acc = in_valid && in_ready;
         if (out_valid) begin
            check($sformatf("bp_order%0d", got), out_data, got + 1);
            if (first_c < 0) first_c = c;
            last_c = c;
            got++;
         end
         tick();
         if (acc) idx++;
      end
      in_valid = 1'b0;
      check("bp_got", got, 12);
      check("bp_stream_span", last_c - first_c, 11);
      check("bp_drained", out_valid, 0);

      // cfg_load ignored while busy
      drain();
      send(5);
      cfg_mult = 16'd4; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      tick(); tick();
      check("cfg_busy_old", out_data, 32'h05);
      drain();
      send(6); tick(); tick(); tick();
      check("cfg_busy_kept", out_data, 32'h06);

      // Mid-stream reset, then default config restored
      drain();
      load_cfg(16'd3, 5'd2, -32'sd1, 1'b1, 2'd1);
      out_ready = 1'b0;
      send(7); send(8); tick(); tick();
      check("mid_pre_valid", out_valid, 1);
      reset = 1'b1; in_valid = 1'b1; in_accum = 32'd9;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", in_ready, 1);
      check("mid_rst_data", out_data, 0);
      tick(); tick(); tick(); tick();
      check("mid_rst_no_ghost", out_valid, 0);
      out_ready = 1'b1;
      send(100); tick(); tick(); tick();
      check("rst_cfg_default", out_data, 32'h64);
      check("rst_cfg_sat", out_sat, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
